// File: rtl/fifo_read_streamer_if.sv
// Handshake bundle for fifo_read_streamer.
// Groups three sets of signals:
//   - the burst request (start, burst_len) and status (busy, done, words_sent);
//   - the synchronous FIFO read port (fifo_cs, fifo_rd_en, fifo_data_out, fifo_empty);
//   - the valid/ready output stream (m_valid, m_ready, m_data).
// master : the streamer's view of the bundle.
// slave  : the environment's view (requester, FIFO and stream sink).
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  busy;
  logic                  done;
  logic [LEN_WIDTH-1:0]  words_sent;

  modport master (
    input  start, burst_len, fifo_data_out, fifo_empty, m_ready,
    output fifo_cs, fifo_rd_en, m_valid, m_data, busy, done, words_sent
  );

  modport slave (
    output start, burst_len, fifo_data_out, fifo_empty, m_ready,
    input  fifo_cs, fifo_rd_en, m_valid, m_data, busy, done, words_sent
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
// Reads a burst of burst_len words from a synchronous FIFO (read data one cycle
// after the pop) and presents them on a valid/ready stream. A 3-entry skid
// buffer absorbs the FIFO read latency, so the pop request never has to look at
// m_ready and the stream still runs at one word per cycle.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_read_streamer_if.master
//            start/burst_len in, busy/done/words_sent out,
//            fifo_cs/fifo_rd_en out, fifo_data_out/fifo_empty in,
//            m_valid/m_data out, m_ready in
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_read_streamer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  words_sent;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] buffer [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occupancy;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  rd_en;
  logic                  pop;
  logic                  cap;
  logic [2:0]            credit_used;
  logic [1:0]            occ_after_pop;
  logic [1:0]            occ_next;
  logic [1:0]            rd_next;
  logic [DATA_WIDTH-1:0] m_data_next;

  // Circular buffer pointers wrap modulo 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check: a word already in the buffer or still on its way from the
  // FIFO both consume a slot, so capping their sum at 3 means a capture can
  // never overflow, whatever the sink does.
  assign credit_used   = {1'b0, occupancy} + {2'b00, in_flight};
  assign rd_en         = (state == RUN) && !bus.fifo_empty &&
                         (remaining != '0) && (credit_used < 3'd3);
  assign pop           = m_valid_r && bus.m_ready;
  assign cap           = in_flight;
  assign occ_after_pop = occupancy - {1'b0, pop};
  assign occ_next      = occ_after_pop + {1'b0, cap};
  assign rd_next       = pop ? ptr_inc(rd_ptr) : rd_ptr;

  // Next head word for the registered m_data. If the pop empties the buffer
  // and a capture lands in the same edge, the new head is the word arriving
  // from the FIFO; otherwise it is already stored. With nothing left, the old
  // value is simply held.
  always_comb begin
    m_data_next = m_data_r;
    if (occ_next != 2'd0) begin
      if (occ_after_pop == 2'd0) begin
        m_data_next = bus.fifo_data_out;
      end else begin
        m_data_next = buffer[rd_next];
      end
    end
  end

  // Buffer storage carries no reset; its contents only matter once occupancy
  // says so, and occupancy is reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      buffer[wr_ptr] <= bus.fifo_data_out;
    end
  end

  // Control FSM plus the buffer bookkeeping. busy and done are registered
  // alongside each state change so they exactly track the state. Reset drops
  // in_flight, so a FIFO word returned after reset release is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      words_sent <= '0;
      in_flight  <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      occupancy  <= 2'd0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_flight <= rd_en;
      occupancy <= occ_next;
      rd_ptr    <= rd_next;
      m_valid_r <= (occ_next != 2'd0);
      m_data_r  <= m_data_next;
      if (cap) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        words_sent <= words_sent + LEN_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            words_sent <= '0;
            remaining  <= bus.burst_len;
            busy_r     <= 1'b1;
            if (bus.burst_len == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (rd_en) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state <= FLUSH;
            end
          end else if (remaining == '0) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (!in_flight && (occupancy == 2'd0)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.fifo_cs    = rd_en;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_data     = m_data_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.words_sent = words_sent;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Testbench for fifo_read_streamer.
// The bench acts as the requester, a synchronous FIFO whose read data appears
// one cycle after the pop, and the stream sink. The reference model works at
// the transaction level:
//   - the stream must replay the FIFO contents in push order;
//   - issued pops minus stream handshakes may not exceed 3;
//   - a burst ends with a single done pulse once burst_len words have gone out.
module tb_fifo_read_streamer;
  localparam int DW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fifo_read_streamer_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_read_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];

  int outstanding;
  int pops_this_burst;
  int rd_count;
  int delivered;
  int done_pulses;
  int edges;
  int first_valid_edge;
  int first_hs_edge;
  int last_hs_edge;
  int cur_len;
  int to_push;
  logic prev_rd;
  logic got_done;
  logic burst_active;
  logic stall_prev;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] first_word;

  // One comparison: counts it and reports a failure with tag and values.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock cycle: check everything visible before the edge, then let the
  // edge happen and update the FIFO and reference model 1 time unit later.
  task automatic tick();
    logic rd;
    logic hs;
    logic done_seen;
    logic [DW-1:0] exp_word;
    @(negedge clk);
    rd        = bus.fifo_rd_en;
    hs        = bus.m_valid && bus.m_ready;
    done_seen = bus.done;
    check_output("cs_follows_rd", 64'(bus.fifo_cs), 64'(rd));
    check_output("m_valid_occ", 64'(bus.m_valid), 64'((outstanding - int'(prev_rd)) > 0));
    check_output("busy", 64'(bus.busy), 64'(burst_active));
    if (rd) begin
      check_output("rd_fifo_nonempty", 64'(fifo_q.size() != 0), 64'(1));
      check_output("rd_credit", 64'(outstanding < 3), 64'(1));
      check_output("rd_remaining", 64'(pops_this_burst < cur_len), 64'(1));
    end
    if (bus.m_valid && !bus.m_ready) begin
      if (stall_prev) check_output("m_data_hold", 64'(bus.m_data), 64'(stall_data));
      stall_prev = 1'b1;
      stall_data = bus.m_data;
    end else begin
      stall_prev = 1'b0;
    end
    if (bus.m_valid && first_valid_edge < 0) first_valid_edge = edges;
    if (hs) begin
      check_output("stream_exp_avail", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check_output("stream_data", 64'(bus.m_data), 64'(exp_word));
      end
      if (first_hs_edge < 0) first_hs_edge = edges;
      last_hs_edge = edges;
      delivered++;
    end
    if (done_seen) begin
      got_done = 1'b1;
      done_pulses++;
      check_output("done_words_sent", 64'(bus.words_sent), 64'(cur_len));
      check_output("done_delivered", 64'(delivered), 64'(cur_len));
    end
    @(posedge clk);
    #1;
    edges++;
    if (rd) begin
      if (fifo_q.size() != 0) bus.fifo_data_out = fifo_q.pop_front();
      pops_this_burst++;
      rd_count++;
    end
    outstanding = outstanding + (rd ? 1 : 0) - (hs ? 1 : 0);
    prev_rd = rd;
    if (done_seen) burst_active = 1'b0;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic apply_stimulus(input int len);
    bus.start       = 1'b1;
    bus.burst_len   = LW'(len);
    cur_len         = len;
    pops_this_burst = 0;
    rd_count        = 0;
    delivered       = 0;
    done_pulses     = 0;
    got_done        = 1'b0;
    first_valid_edge = -1;
    first_hs_edge   = -1;
    last_hs_edge    = -1;
    tick();
    bus.start    = 1'b0;
    burst_active = 1'b1;
    edges        = 0;
  endtask

  // ready_mode 0: hold m_ready, 1: toggle each cycle, 2: random m_ready plus
  // random refills of the FIFO until to_push words have been added.
  task automatic run_until_done(input int ready_mode, input int max_ticks);
    int n;
    n = 0;
    while (!got_done && n < max_ticks) begin
      if (ready_mode == 1) begin
        bus.m_ready = ~bus.m_ready;
      end else if (ready_mode == 2) begin
        bus.m_ready = ($urandom_range(0, 3) != 0);
        if (to_push > 0 && $urandom_range(0, 2) == 0) begin
          push_word(DW'($urandom));
          to_push--;
        end
      end
      tick();
      n++;
    end
    check_output("done_reached", 64'(got_done), 64'(1));
  endtask

  task automatic finish_burst();
    check_output("done_one_cycle", 64'(bus.done), 64'(0));
    check_output("busy_fell", 64'(bus.busy), 64'(0));
    check_output("done_pulse_count", 64'(done_pulses), 64'(1));
    check_output("pops_equal_len", 64'(pops_this_burst), 64'(cur_len));
    tick();
    tick();
    check_output("words_sent_hold", 64'(bus.words_sent), 64'(cur_len));
  endtask

  task automatic check_reset_outputs();
    check_output("rst_fifo_cs", 64'(bus.fifo_cs), 64'(0));
    check_output("rst_fifo_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    check_output("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check_output("rst_busy", 64'(bus.busy), 64'(0));
    check_output("rst_done", 64'(bus.done), 64'(0));
    check_output("rst_m_data", 64'(bus.m_data), 64'(0));
    check_output("rst_words_sent", 64'(bus.words_sent), 64'(0));
  endtask

  task automatic model_reset();
    outstanding  = 0;
    prev_rd      = 1'b0;
    burst_active = 1'b0;
    stall_prev   = 1'b0;
    exp_q        = fifo_q;
  endtask

  initial begin
    int len;
    int pre;
    bus.start         = 1'b0;
    bus.burst_len     = '0;
    bus.fifo_data_out = '0;
    bus.fifo_empty    = 1'b1;
    bus.m_ready       = 1'b0;
    cur_len = 0;
    pops_this_burst = 0;
    delivered = 0;
    edges = 0;
    to_push = 0;
    model_reset();

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    $display("[TB] three-word burst, sink always ready");
    push_word(32'd1);
    push_word(32'd10);
    push_word(32'd100);
    bus.m_ready = 1'b1;
    apply_stimulus(3);
    run_until_done(0, 50);
    check_output("lat_first_valid", 64'(first_valid_edge), 64'(2));
    check_output("lat_first_hs", 64'(first_hs_edge), 64'(2));
    check_output("thru_back_to_back", 64'(last_hs_edge - first_hs_edge), 64'(2));
    finish_burst();

    $display("[TB] eight powers of two, sink toggling");
    for (int i = 0; i < 8; i++) push_word(DW'(1) << i);
    bus.m_ready = 1'b1;
    apply_stimulus(8);
    run_until_done(1, 100);
    finish_burst();

    $display("[TB] FIFO runs dry mid-burst, refill later");
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    apply_stimulus(5);
    for (int i = 0; i < 10; i++) begin
      bus.start     = (i == 4);
      bus.burst_len = LW'(9);
      tick();
    end
    bus.start = 1'b0;
    check_output("dry_delivered", 64'(delivered), 64'(3));
    check_output("dry_still_busy", 64'(bus.busy), 64'(1));
    for (int i = 0; i < 2; i++) push_word(DW'($urandom));
    run_until_done(0, 50);
    finish_burst();

    $display("[TB] zero-length burst");
    apply_stimulus(0);
    check_output("zero_done_next", 64'(bus.done), 64'(1));
    run_until_done(0, 5);
    check_output("zero_no_reads", 64'(rd_count), 64'(0));
    finish_burst();

    $display("[TB] sink stalled for an eight-word burst");
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    first_word = exp_q[0];
    apply_stimulus(8);
    repeat (10) tick();
    check_output("stall_pops", 64'(rd_count), 64'(3));
    check_output("stall_m_data", 64'(bus.m_data), 64'(first_word));
    check_output("stall_m_valid", 64'(bus.m_valid), 64'(1));
    bus.m_ready = 1'b1;
    run_until_done(0, 50);
    finish_burst();

    $display("[TB] reset mid-burst");
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DW'($urandom));
    apply_stimulus(8);
    for (int i = 0; i < 50 && delivered < 4; i++) tick();
    check_output("pre_reset_delivered", 64'(delivered), 64'(4));
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    apply_stimulus(2);
    run_until_done(0, 50);
    finish_burst();

    $display("[TB] random bursts");
    for (int b = 0; b < 4; b++) begin
      len = $urandom_range(3, 12);
      pre = $urandom_range(0, len);
      for (int i = 0; i < pre; i++) push_word(DW'($urandom));
      to_push = len - pre;
      apply_stimulus(len);
      run_until_done(2, 400);
      finish_burst();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fifo_read_streamer.md
FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO and stream data.
REQ-002 Parameter LEN_WIDTH, default 16, width of burst length and word counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 burst_len  input  LEN_WIDTH  number of words to transfer; captured when start is accepted.
REQ-007 fifo_cs  output  1  chip select to the synchronous FIFO read port.
REQ-008 fifo_rd_en  output  1  pop request to the FIFO.
REQ-009 fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after the edge that sampled fifo_rd_en=1.
REQ-010 fifo_empty  input  1  FIFO empty flag.
REQ-011 m_valid  output  1  stream data valid.
REQ-012 m_ready  input  1  stream sink ready.
REQ-013 m_data  output  DATA_WIDTH  stream data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at burst completion.
REQ-016 words_sent  output  LEN_WIDTH  count of stream handshakes in the current/last burst.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH, and DONE.
- IDLE -> RUN on start=1: capture burst_len into remaining; clear words_sent.
- IDLE -> DONE on start=1 with burst_len=0.
- RUN -> FLUSH when remaining reaches 0 after the last pop is issued.
- FLUSH -> DONE when in-flight=0 and buffer occupancy=0.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 fifo_rd_en SHALL be combinational: 1 iff state=RUN, fifo_empty=0, remaining>0, and (occupancy + in-flight) < 3.
- It SHALL never depend combinationally on m_ready.
REQ-020 fifo_cs SHALL equal fifo_rd_en.
REQ-021 Each cycle with fifo_rd_en=1 SHALL decrement remaining by 1 and set the in-flight register at the next edge.
- In-flight is cleared at the next edge otherwise.
REQ-022 When in-flight=1, fifo_data_out SHALL be written into the tail of a 3-entry circular buffer at that edge.
REQ-023 Buffer pointers SHALL wrap modulo 3, and occupancy SHALL range 0..3.
- The credit rule in REQ-019 guarantees a capture never overflows the buffer.
REQ-024 m_valid SHALL be (occupancy>0), and m_data SHALL be the head entry, registered with no combinational path from fifo_data_out.
REQ-025 When m_valid=1 and m_ready=1, the head SHALL pop and words_sent SHALL increment at that edge.
REQ-026 A simultaneous capture and pop SHALL leave occupancy unchanged and preserve order.
REQ-027 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 Latency: the first m_valid SHALL rise two edges after the edge that accepted start, given a non-empty FIFO.
REQ-029 With the FIFO non-empty and m_ready held at 1, throughput SHALL be one word per cycle.
REQ-030 If fifo_empty=1 in RUN, the block SHALL stall issuing reads, keep draining the buffer, and resume when fifo_empty falls.
REQ-031 done SHALL be 1 exactly in state DONE.
REQ-032 words_sent SHALL equal burst_len at the done pulse and hold until the next accepted start.

Reset
REQ-033 While rst_n=0:
- state=IDLE.
- fifo_cs, fifo_rd_en, m_valid, busy, done = 0.
- m_data, words_sent, remaining = 0.
- In-flight = 0, buffer occupancy = 0, pointers = 0.
REQ-034 Reset asserted mid-burst SHALL discard buffered and in-flight data.
- FIFO data returned after reset release SHALL not be captured.

Verification
REQ-035 FIFO preloaded with 1, 10, 100; start with burst_len=3; m_ready=1.
- Response: m_data 1, 10, 100 on three consecutive cycles, first m_valid two edges after start.
- Then done pulses once, words_sent=3, busy falls.
REQ-036 FIFO holds 2**0..2**7; burst_len=8; m_ready toggles 1/0 each cycle.
- Response: eight values in order, none lost or duplicated.
- fifo_rd_en never high while occupancy+in-flight=3.
REQ-037 FIFO holds 3 words; burst_len=5; 2 more words written 10 cycles later.
- Response: 3 words delivered, fifo_rd_en low while fifo_empty=1, remaining 2 delivered after the refill, done with words_sent=5.
REQ-038 start with burst_len=0.
- Response: done pulses on the next cycle, fifo_rd_en never asserts, words_sent=0.
REQ-039 Hold m_ready=0 during an 8-word burst.
- Response: exactly 3 pops issued, m_data stable at the first word.
- After m_ready=1, the remaining words stream in order.
REQ-040 rst_n pulsed low mid-burst after 4 of 8 words, then start with burst_len=2.
- Response: all outputs 0 during reset, no stale word appears.
- The next two FIFO words are delivered and done pulses.
